// File: rtl/osd_pkg.sv
// Shared constants, types and helpers for the centred on-screen-display overlay.
package osd_pkg;

  localparam int unsigned OSD_W      = 256;
  localparam int unsigned OSD_H      = 64;
  localparam int unsigned LATENCY    = 2;
  localparam logic [5:0]  TINT       = 6'h10;
  localparam logic [5:0]  WHITE      = 6'h3F;

  localparam int unsigned ROW_GRP_W  = 3;
  localparam int unsigned COL_W      = 8;
  localparam int unsigned LINE_SEL_W = 3;
  localparam int unsigned ADDR_W     = ROW_GRP_W + COL_W;
  localparam int unsigned Y_W        = ROW_GRP_W + LINE_SEL_W;
  localparam int unsigned RAM_DEPTH  = 1 << ADDR_W;

  localparam int unsigned CNT_W      = 10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic [5:0] r;
    logic [5:0] g;
    logic [5:0] b;
  } video_t;

  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/osd_ram.sv
// Bitmap store: simple dual-port RAM, one clock, registered read (old data on a collision).
module osd_ram
  import osd_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_wr,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [7:0]        i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [7:0]        o_rd_data
);

  logic [7:0] r_mem [RAM_DEPTH];
  logic [7:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/osd_overlay.sv
// Measures the incoming raster, centres a 1-bpp bitmap window on it and blends it into
// the video with a fixed two-clock latency.
module osd_overlay #(
  parameter int unsigned OSD_W = osd_pkg::OSD_W,
  parameter int unsigned OSD_H = osd_pkg::OSD_H
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_osd_enable,
  input  logic                      i_osd_wr,
  input  logic [osd_pkg::ADDR_W-1:0] i_osd_addr,
  input  logic [7:0]                i_osd_data,
  input  logic                      i_hs,
  input  logic                      i_vs,
  input  logic [5:0]                i_r,
  input  logic [5:0]                i_g,
  input  logic [5:0]                i_b,
  output logic                      o_hs,
  output logic                      o_vs,
  output logic [5:0]                o_r,
  output logic [5:0]                o_g,
  output logic [5:0]                o_b
);

  import osd_pkg::*;

  localparam cnt_t OSD_W_C = cnt_t'(OSD_W);
  localparam cnt_t OSD_H_C = cnt_t'(OSD_H);

  // Raster measurement state
  logic r_hs_q, r_vs_q;
  cnt_t r_hcnt, r_vcnt, r_h_total, r_v_total;
  logic r_h_seen, r_h_valid, r_v_seen, r_v_valid, r_en_frame;

  // Pipeline state
  video_t                r_vid1;
  logic                  r_win1;
  logic [LINE_SEL_W-1:0] r_bit_sel1;
  video_t                r_out;

  logic                  w_ls, w_fs;
  cnt_t                  w_hcnt, w_vcnt_inc, w_vcnt, w_h_total, w_v_total;
  logic                  w_h_valid, w_v_valid, w_en_frame;
  cnt_t                  w_h_start, w_v_start;
  logic [CNT_W:0]        w_h_end, w_v_end;
  logic                  w_h_fit, w_v_fit, w_h_in, w_v_in, w_win;
  logic [COL_W-1:0]      w_x;
  logic [Y_W-1:0]        w_y;
  logic [ADDR_W-1:0]     w_rd_addr;
  logic [7:0]            w_rd_data;
  logic                  w_bit;
  video_t                w_out;

  // The w_ values describe the pixel currently on the inputs, so the pixel where hsync
  // falls is hcnt 0 and totals hold the uncleared count (number of clocks/lines).
  always_comb begin
    w_ls       = r_hs_q & ~i_hs;
    w_fs       = r_vs_q & ~i_vs;
    w_hcnt     = w_ls ? '0 : sat_inc(r_hcnt);
    w_vcnt_inc = w_ls ? sat_inc(r_vcnt) : r_vcnt;
    w_vcnt     = w_fs ? '0 : w_vcnt_inc;
    w_h_total  = w_ls ? sat_inc(r_hcnt) : r_h_total;
    w_v_total  = w_fs ? w_vcnt_inc : r_v_total;
    // A total is trusted only once a full line/frame has elapsed since reset.
    w_h_valid  = r_h_valid | (w_ls & r_h_seen);
    w_v_valid  = r_v_valid | (w_fs & r_v_seen);
    w_en_frame = w_fs ? i_osd_enable : r_en_frame;
  end

  always_comb begin
    w_h_start = (w_h_total - OSD_W_C) >> 1;
    w_v_start = (w_v_total - OSD_H_C) >> 1;
    w_h_end   = {1'b0, w_h_start} + {1'b0, OSD_W_C};
    w_v_end   = {1'b0, w_v_start} + {1'b0, OSD_H_C};
    w_h_fit   = (w_h_total >= OSD_W_C);
    w_v_fit   = (w_v_total >= OSD_H_C);
    w_h_in    = (w_hcnt >= w_h_start) && ({1'b0, w_hcnt} < w_h_end);
    w_v_in    = (w_vcnt >= w_v_start) && ({1'b0, w_vcnt} < w_v_end);
    w_win     = w_en_frame & w_h_valid & w_v_valid & w_h_fit & w_v_fit & w_h_in & w_v_in;
    w_x       = w_hcnt[COL_W-1:0] - w_h_start[COL_W-1:0];
    w_y       = w_vcnt[Y_W-1:0] - w_v_start[Y_W-1:0];
    w_rd_addr = {w_y[Y_W-1:LINE_SEL_W], w_x};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hs_q     <= 1'b0;
      r_vs_q     <= 1'b0;
      r_hcnt     <= '0;
      r_vcnt     <= '0;
      r_h_total  <= '0;
      r_v_total  <= '0;
      r_h_seen   <= 1'b0;
      r_h_valid  <= 1'b0;
      r_v_seen   <= 1'b0;
      r_v_valid  <= 1'b0;
      r_en_frame <= 1'b0;
    end else begin
      r_hs_q     <= i_hs;
      r_vs_q     <= i_vs;
      r_hcnt     <= w_hcnt;
      r_vcnt     <= w_vcnt;
      r_h_total  <= w_h_total;
      r_v_total  <= w_v_total;
      r_h_seen   <= r_h_seen | w_ls;
      r_h_valid  <= w_h_valid;
      r_v_seen   <= r_v_seen | w_fs;
      r_v_valid  <= w_v_valid;
      r_en_frame <= w_en_frame;
    end
  end

  osd_ram u_ram (
    .i_clk     (i_clk),
    .i_wr      (i_osd_wr),
    .i_wr_addr (i_osd_addr),
    .i_wr_data (i_osd_data),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  always_comb begin
    w_bit = w_rd_data[r_bit_sel1];
    w_out = r_vid1;
    if (r_win1) begin
      if (w_bit) begin
        w_out.r = WHITE;
        w_out.g = WHITE;
        w_out.b = WHITE;
      end else begin
        w_out.r = r_vid1.r >> 1;
        w_out.g = r_vid1.g >> 1;
        w_out.b = (r_vid1.b >> 1) + TINT;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_vid1     <= '0;
      r_win1     <= 1'b0;
      r_bit_sel1 <= '0;
      r_out      <= '0;
    end else begin
      r_vid1     <= {i_hs, i_vs, i_r, i_g, i_b};
      r_win1     <= w_win;
      r_bit_sel1 <= w_y[LINE_SEL_W-1:0];
      r_out      <= w_out;
    end
  end

  assign o_hs = r_out.hs;
  assign o_vs = r_out.vs;
  assign o_r  = r_out.r;
  assign o_g  = r_out.g;
  assign o_b  = r_out.b;

endmodule

// File: tb/tb_osd_overlay.sv
// Directed bench: small 16x16 overlay on a 40-clock x 24-line raster (h_start 12, v_start 4).
module tb_osd_overlay;

  localparam int unsigned OW = 16;
  localparam int unsigned OH = 16;
  localparam int NFR = 15;

  logic        clk = 1'b0;
  logic        reset, osd_enable, osd_wr;
  logic [10:0] osd_addr;
  logic [7:0]  osd_data;
  logic        hs, vs;
  logic [5:0]  r_in, g_in, b_in;
  logic        hs_o, vs_o;
  logic [5:0]  r_o, g_o, b_o;

  always #5 clk = ~clk;

  osd_overlay #(
    .OSD_W (OW),
    .OSD_H (OH)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_osd_enable (osd_enable),
    .i_osd_wr     (osd_wr),
    .i_osd_addr   (osd_addr),
    .i_osd_data   (osd_data),
    .i_hs         (hs),
    .i_vs         (vs),
    .i_r          (r_in),
    .i_g          (g_in),
    .i_b          (b_in),
    .o_hs         (hs_o),
    .o_vs         (vs_o),
    .o_r          (r_o),
    .o_g          (g_o),
    .o_b          (b_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver position, read by the monitor to tag each input pixel
  int   cur_fr = 0, cur_h = 0, cur_v = 0;
  logic drv_valid = 1'b0;
  logic solid = 1'b1;

  typedef struct packed {
    logic        valid;
    logic        hs;
    logic        vs;
    logic [17:0] rgb;
    logic [3:0]  fr;
    logic [5:0]  h;
    logic [4:0]  v;
  } ent_t;

  ent_t        h1, h2;
  logic [17:0] out_mem [NFR][24][40];
  int          diff_cnt [NFR];
  int          sync_err = 0;

  // Output at negedge of cycle t belongs to the input pixel of cycle t-2.
  initial begin
    h1 = '0;
    h2 = '0;
    forever begin
      @(negedge clk);
      if (h2.valid) begin
        if ({hs_o, vs_o} !== {h2.hs, h2.vs}) sync_err++;
        out_mem[h2.fr][h2.v][h2.h] = {r_o, g_o, b_o};
        if ({r_o, g_o, b_o} !== h2.rgb) diff_cnt[h2.fr]++;
      end
      h2       = h1;
      h1.valid = drv_valid;
      h1.hs    = hs;
      h1.vs    = vs;
      h1.rgb   = {r_in, g_in, b_in};
      h1.fr    = 4'(cur_fr);
      h1.h     = 6'(cur_h);
      h1.v     = 5'(cur_v);
      if (reset) begin
        h1.valid = 1'b0;
        h2.valid = 1'b0;
      end
    end
  end

  task automatic run_frame(input int len, input int lines, input int en_v, input int rst_v,
                           input int wr_v);
    for (int v = 0; v < lines; v++) begin
      for (int h = 0; h < len; h++) begin
        cur_h     = h;
        cur_v     = v;
        drv_valid = 1'b1;
        hs        = (h >= 4);
        vs        = (v >= 2);
        r_in      = solid ? 6'h20 : 6'(h);
        g_in      = solid ? 6'h20 : 6'(v);
        b_in      = solid ? 6'h20 : 6'h3F;
        if (v == en_v && h == 0) osd_enable = 1'b1;
        osd_wr    = (v == wr_v && h == 17);
        reset     = (v == rst_v && h == 20);
        @(posedge clk);
        #1;
        if (reset) check_eq("rst_mid_zero", {12'h0, hs_o, vs_o, r_o, g_o, b_o}, 32'h0);
      end
    end
    reset  = 1'b0;
    osd_wr = 1'b0;
    cur_fr++;
  endtask

  task automatic ram_write(input logic [10:0] a, input logic [7:0] d);
    osd_wr   = 1'b1;
    osd_addr = a;
    osd_data = d;
    @(posedge clk);
    #1;
    osd_wr   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; osd_enable = 1'b0; osd_wr = 1'b0; osd_addr = '0; osd_data = '0;
    hs = 1'b1; vs = 1'b1; r_in = 6'h15; g_in = 6'h15; b_in = 6'h15;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out", {12'h0, hs_o, vs_o, r_o, g_o, b_o}, 32'h0);
    reset = 1'b0;

    for (int a = 0; a < 2048; a++) ram_write(11'(a), 8'h00);
    ram_write(11'h000, 8'h01);
    ram_write(11'h00F, 8'h80);
    ram_write(11'h100, 8'h02);
    osd_enable = 1'b1;

    solid = 1'b1;
    run_frame(40, 24, -1, -1, -1);   // fr0: measuring only
    run_frame(40, 24, -1, -1, -1);   // fr1: overlay
    solid = 1'b0;
    run_frame(40, 24, -1, -1, -1);   // fr2: varying data
    run_frame(12, 24, -1, -1, -1);   // fr3: line shorter than window
    run_frame(12, 24, -1, -1, -1);   // fr4
    solid = 1'b1;
    run_frame(40, 24, -1, -1, -1);   // fr5
    run_frame(40, 12, -1, -1, -1);   // fr6: frame shorter than window
    run_frame(40, 12, -1, -1, -1);   // fr7
    run_frame(40, 24, -1, -1, -1);   // fr8
    osd_enable = 1'b0;
    run_frame(40, 24, 10, -1, -1);   // fr9: enable rises mid-frame
    osd_addr = 11'h105;
    osd_data = 8'hFF;
    run_frame(40, 24, -1, -1, 13);   // fr10: write collides with read of 0x105
    run_frame(40, 24, -1, -1, -1);   // fr11
    run_frame(40, 24, -1, 10, -1);   // fr12: reset mid-window
    run_frame(40, 24, -1, -1, -1);   // fr13
    run_frame(40, 24, -1, -1, -1);   // fr14
    drv_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    check_eq("f0_no_ovl",      diff_cnt[0], 0);
    check_eq("f1_px_on",       32'(out_mem[1][4][12]),  32'({6'h3F, 6'h3F, 6'h3F}));
    check_eq("f1_px_tint",     32'(out_mem[1][4][13]),  32'({6'h10, 6'h10, 6'h20}));
    check_eq("f1_left",        32'(out_mem[1][4][11]),  32'({6'h20, 6'h20, 6'h20}));
    check_eq("f1_right",       32'(out_mem[1][4][28]),  32'({6'h20, 6'h20, 6'h20}));
    check_eq("f1_top",         32'(out_mem[1][3][12]),  32'({6'h20, 6'h20, 6'h20}));
    check_eq("f1_bottom",      32'(out_mem[1][20][12]), 32'({6'h20, 6'h20, 6'h20}));
    check_eq("f1_corner_bit7", 32'(out_mem[1][11][27]), 32'({6'h3F, 6'h3F, 6'h3F}));
    check_eq("f1_grp1_bit1",   32'(out_mem[1][13][12]), 32'({6'h3F, 6'h3F, 6'h3F}));
    check_eq("f1_last_row",    32'(out_mem[1][19][12]), 32'({6'h10, 6'h10, 6'h20}));
    check_eq("f1_window_px",   diff_cnt[1], 256);
    check_eq("f2_tint_var",    32'(out_mem[2][10][20]), 32'({6'h0A, 6'h05, 6'h2F}));
    check_eq("f2_pass_var",    32'(out_mem[2][10][30]), 32'({6'h1E, 6'h0A, 6'h3F}));
    check_eq("f3_short_line",  diff_cnt[3], 0);
    check_eq("f4_short_line",  diff_cnt[4], 0);
    check_eq("f5_window_px",   diff_cnt[5], 256);
    check_eq("f7_short_frame", diff_cnt[7], 0);
    check_eq("f8_after_short", diff_cnt[8], 0);
    check_eq("f9_en_midframe", diff_cnt[9], 0);
    check_eq("f10_en_next",    diff_cnt[10], 256);
    check_eq("f10_wr_old",     32'(out_mem[10][13][17]), 32'({6'h10, 6'h10, 6'h20}));
    check_eq("f11_wr_new",     32'(out_mem[11][13][17]), 32'({6'h3F, 6'h3F, 6'h3F}));
    check_eq("f12_rst_pass",   32'(out_mem[12][12][20]), 32'({6'h20, 6'h20, 6'h20}));
    check_eq("f13_rst_no_ovl", diff_cnt[13], 0);
    check_eq("f14_ram_kept",   32'(out_mem[14][4][12]), 32'({6'h3F, 6'h3F, 6'h3F}));
    check_eq("f14_window_px",  diff_cnt[14], 256);
    check_eq("sync_delay",     sync_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
